l2_request_arbiter_rr: RTL and testbench
========================================

Name: l2_request_arbiter_rr

Overview:
- Parametrised successor to the fixed 4-master L2 A/C request arbiter.
- Arbitrates NUM_MASTERS TileLink Channel A and Channel C requestors into a single registered output slot feeding the L2 request pipeline.
- Channel C has priority over Channel A. Within each channel, a true wrap-around round-robin pointer applies.
- Output is a one-entry valid/ready register: full throughput, one-cycle latency, opcode forwarded with the grant.

Parameters:
- NUM_MASTERS, 4, number of requesting masters; legal range 2..16.
- OPCODE_W, 3, TileLink opcode width per master.
- A_STARVE_LIMIT, 8, consecutive C grants allowed while A is pending before A is forced (starvation guard only); legal range ≥1.
- ID_W (localparam), $clog2(NUM_MASTERS), master index width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- a_valid_i  in  NUM_MASTERS  Channel A request valid, bit i = master i.
- a_opcode_i  in  NUM_MASTERS*OPCODE_W  packed A opcodes; master i occupies [i*OPCODE_W +: OPCODE_W].
- a_ready_o  out  NUM_MASTERS  Channel A accept, at most one bit set.
- c_valid_i  in  NUM_MASTERS  Channel C request valid.
- c_opcode_i  in  NUM_MASTERS*OPCODE_W  packed C opcodes.
- c_ready_o  out  NUM_MASTERS  Channel C accept, at most one bit set.
- arb_valid  out  1  output slot holds a granted request.
- arb_channel  out  1  0 = Channel A, 1 = Channel C.
- arb_master_oh  out  NUM_MASTERS  one-hot granted master.
- arb_master_id  out  ID_W  binary granted master.
- arb_opcode  out  OPCODE_W  opcode of the granted request.
- arb_ready  in  1  downstream accepts the slot contents.
- arb_busy  out  1  arb_valid OR any a_valid_i/c_valid_i bit set (combinational).

Behaviour:
- Reset (rst high at a clk edge): arb_valid=0, arb_channel=0, arb_master_oh=0, arb_master_id=0, arb_opcode=0, both RR pointers=0, starve count=0.
- During reset, a_ready_o=0 and c_ready_o=0 combinationally. Reset mid-transfer drops the slot contents; no grant is issued in a cycle where rst=1.
- load = !rst && (!arb_valid || arb_ready) && (any A valid || any C valid).
- Arbitration runs combinationally every cycle:
  - Channel pick: C if any c_valid_i bit is set, else A. Starvation-guard override below.
  - Master pick within the chosen channel: the first valid index found scanning ptr, ptr+1, …, NUM_MASTERS-1, 0, …, ptr-1 (modulo NUM_MASTERS).
- On load:
  - The ready bit of the picked master on the picked channel is asserted in the same cycle. All other ready bits are 0. Ready is combinational from valid; no ready when !load.
  - At the clk edge: slot registers take channel, one-hot, binary id and that master's opcode; arb_valid=1.
  - The chosen channel's pointer becomes (picked index + 1) mod NUM_MASTERS, computed in ID_W+1 bits. The other channel's pointer is unchanged.
- No load and arb_ready=1: arb_valid clears at the next edge.
- No load and arb_ready=0 with arb_valid=1: all slot fields hold stable (no change while stalled).
- Back-to-back: arb_valid=1, arb_ready=1 and a pending request cause a reload in the same cycle, giving one grant per cycle sustained.
- Requests may deassert at any time. A master not granted that cycle is simply not considered; no state is kept per request.
- NUM_MASTERS not a power of 2: pointer wrap uses an explicit compare to NUM_MASTERS-1, never bit truncation.

Optional Feature:
- Macro L2_ARB_A_STARVE_GUARD_EN.
- Defined:
  - A counter of width $clog2(A_STARVE_LIMIT+1) increments on each C load while any a_valid_i bit is set.
  - It clears on any A load, or in any cycle with no A valid.
  - When the count == A_STARVE_LIMIT, the next load picks channel A even if C is valid, then the count clears. The count saturates at the limit.
- Not defined: no counter; C strictly wins whenever it is valid.

Test Plan:
- Reset then a_valid_i=4'b1010, arb_ready=1 → cycle 0: a_ready_o=4'b0010. Next cycle: arb_valid=1, arb_master_id=1, arb_channel=0. Following grant: master 3. Then master 1 again.
- a_valid_i=4'b0001 and c_valid_i=4'b0100 held → C master 2 is granted every cycle; a_ready_o stays 0 (guard off).
- Grant loaded, arb_ready=0 for 5 cycles while other masters request → outputs stable, all ready bits 0. arb_ready=1 → next grant loads in that same cycle.
- NUM_MASTERS=5, all five A masters valid continuously → grant order 0,1,2,3,4,0; pointer wraps from 4 to 0.
- Guard on, A_STARVE_LIMIT=2, a_valid_i=1 and c_valid_i=1 held, arb_ready=1 → grant sequence C,C,A,C,C,A.
- rst asserted while arb_valid=1 and arb_ready=0 → next cycle arb_valid=0, pointers=0, no ready asserted during the reset cycle.

Source files
------------

// File: rtl/l2_request_arbiter_rr.sv
// Round-robin L2 Channel A/C request arbiter feeding a one-entry valid/ready output slot.
// Optional A-starvation guard enabled by defining L2_ARB_A_STARVE_GUARD_EN.
module l2_request_arbiter_rr #(
   parameter int NUM_MASTERS    = 4,
   parameter int OPCODE_W       = 3,
   parameter int A_STARVE_LIMIT = 8,
   localparam int ID_W          = $clog2(NUM_MASTERS)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_MASTERS-1:0]          a_valid_i,
   input  logic [NUM_MASTERS*OPCODE_W-1:0] a_opcode_i,
   output logic [NUM_MASTERS-1:0]          a_ready_o,
   input  logic [NUM_MASTERS-1:0]          c_valid_i,
   input  logic [NUM_MASTERS*OPCODE_W-1:0] c_opcode_i,
   output logic [NUM_MASTERS-1:0]          c_ready_o,
   output logic                         arb_valid,
   output logic                         arb_channel,
   output logic [NUM_MASTERS-1:0]          arb_master_oh,
   output logic [ID_W-1:0]              arb_master_id,
   output logic [OPCODE_W-1:0]          arb_opcode,
   input  logic                         arb_ready,
   output logic                         arb_busy
);

   typedef enum logic {CH_A = 1'b0, CH_C = 1'b1} chan_e;

   if (NUM_MASTERS < 2 || NUM_MASTERS > 16) begin : g_bad_masters
      $error("NUM_MASTERS must be in 2..16");
   end
   if (A_STARVE_LIMIT < 1) begin : g_bad_limit
      $error("A_STARVE_LIMIT must be at least 1");
   end

   logic [ID_W-1:0]        ptr_a, ptr_c;
   logic                   a_any, c_any, force_a, load;
   chan_e                  pick_ch;
   logic [ID_W-1:0]        a_idx, c_idx, pick_idx, next_ptr;
   logic [ID_W:0]          ptr_inc;
   logic [NUM_MASTERS-1:0] pick_oh;
   logic [OPCODE_W-1:0]    pick_op;

   // First valid index scanning ptr upward with wrap; the sum is reduced by an
   // explicit compare so non-power-of-2 master counts wrap correctly.
   function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_MASTERS-1:0] valid,
                                               input logic [ID_W-1:0] ptr);
      logic [ID_W:0]   cand;
      logic            found;
      logic [ID_W-1:0] idx;
      found = 1'b0;
      idx   = '0;
      for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
         cand = {1'b0, ptr} + (ID_W+1)'(k);
         if (cand >= (ID_W+1)'(NUM_MASTERS))
            cand = cand - (ID_W+1)'(NUM_MASTERS);
         if (!found && valid[cand[ID_W-1:0]]) begin
            found = 1'b1;
            idx   = cand[ID_W-1:0];
         end
      end
      return idx;
   endfunction

   assign a_any = |a_valid_i;
   assign c_any = |c_valid_i;
   assign load  = !rst && (!arb_valid || arb_ready) && (a_any || c_any);

`ifdef L2_ARB_A_STARVE_GUARD_EN
   localparam int CNT_W = $clog2(A_STARVE_LIMIT + 1);
   logic [CNT_W-1:0] starve_cnt;

   assign force_a = a_any && (starve_cnt == CNT_W'(A_STARVE_LIMIT));

   always_ff @(posedge clk) begin
      if (rst)
         starve_cnt <= '0;
      else if (!a_any || (load && pick_ch == CH_A))
         starve_cnt <= '0;
      else if (load && pick_ch == CH_C && starve_cnt != CNT_W'(A_STARVE_LIMIT))
         starve_cnt <= starve_cnt + 1'b1;
   end
`else
   assign force_a = 1'b0;
`endif

   always_comb begin
      a_idx    = rr_pick(a_valid_i, ptr_a);
      c_idx    = rr_pick(c_valid_i, ptr_c);
      pick_ch  = (c_any && !force_a) ? CH_C : CH_A;
      pick_idx = (pick_ch == CH_C) ? c_idx : a_idx;
      pick_oh  = NUM_MASTERS'(1) << pick_idx;
      pick_op  = (pick_ch == CH_C) ? c_opcode_i[int'(pick_idx)*OPCODE_W +: OPCODE_W]
                                   : a_opcode_i[int'(pick_idx)*OPCODE_W +: OPCODE_W];
      ptr_inc  = {1'b0, pick_idx} + 1'b1;
      next_ptr = (ptr_inc == (ID_W+1)'(NUM_MASTERS)) ? '0 : ptr_inc[ID_W-1:0];
   end

   assign a_ready_o = (load && pick_ch == CH_A) ? pick_oh : '0;
   assign c_ready_o = (load && pick_ch == CH_C) ? pick_oh : '0;
   assign arb_busy  = arb_valid || a_any || c_any;

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_a <= '0;
         ptr_c <= '0;
      end else if (load) begin
         if (pick_ch == CH_C) ptr_c <= next_ptr;
         else                 ptr_a <= next_ptr;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         arb_valid     <= 1'b0;
         arb_channel   <= 1'b0;
         arb_master_oh <= '0;
         arb_master_id <= '0;
         arb_opcode    <= '0;
      end else if (load) begin
         arb_valid     <= 1'b1;
         arb_channel   <= (pick_ch == CH_C);
         arb_master_oh <= pick_oh;
         arb_master_id <= pick_idx;
         arb_opcode    <= pick_op;
      end else if (arb_ready) begin
         arb_valid     <= 1'b0;
      end
   end

endmodule

// File: tb/tb_l2_request_arbiter_rr.sv
// Randomised and directed bench for l2_request_arbiter_rr (5 masters, starve limit 2).
// Guard expectations follow L2_ARB_A_STARVE_GUARD_EN as defined for the build.
module tb_l2_request_arbiter_rr;
   localparam int N   = 5;
   localparam int OW  = 3;
   localparam int LIM = 2;
   localparam int IDW = $clog2(N);
`ifdef L2_ARB_A_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N-1:0]    a_valid = '0, c_valid = '0, a_ready, c_ready;
   logic [N*OW-1:0] a_op = '0, c_op = '0;
   logic            arb_valid, arb_channel, arb_busy;
   logic            arb_ready = 1'b1;
   logic [N-1:0]    arb_oh;
   logic [IDW-1:0]  arb_id;
   logic [OW-1:0]   arb_opcode;

   int errors = 0;
   int checks = 0;

   l2_request_arbiter_rr #(.NUM_MASTERS(N), .OPCODE_W(OW), .A_STARVE_LIMIT(LIM)) dut (
      .clk(clk), .rst(rst),
      .a_valid_i(a_valid), .a_opcode_i(a_op), .a_ready_o(a_ready),
      .c_valid_i(c_valid), .c_opcode_i(c_op), .c_ready_o(c_ready),
      .arb_valid(arb_valid), .arb_channel(arb_channel), .arb_master_oh(arb_oh),
      .arb_master_id(arb_id), .arb_opcode(arb_opcode), .arb_ready(arb_ready),
      .arb_busy(arb_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: per-channel pointers, slot contents and starvation count.
   int m_ptr[2];
   int m_cnt;
   bit m_valid;
   int m_ch, m_id, m_op;
   bit model_live = 1'b0;

   function automatic int rr_first(input logic [N-1:0] v, input int ptr);
      for (int k = 0; k < N; k++)
         if (v[(ptr + k) % N]) return (ptr + k) % N;
      return 0;
   endfunction

   always @(negedge clk) begin
      bit a_any, c_any, force_a, load;
      int ch, idx;
      logic [N-1:0] exp_ar, exp_cr, onehot;
      a_any   = |a_valid;
      c_any   = |c_valid;
      force_a = GUARD && a_any && (m_cnt == LIM);
      ch      = (c_any && !force_a) ? 1 : 0;
      idx     = rr_first(ch ? c_valid : a_valid, m_ptr[ch]);
      load    = !rst && (!m_valid || arb_ready) && (a_any || c_any);
      onehot  = '0;
      onehot[idx] = 1'b1;
      exp_ar  = (load && ch == 0) ? onehot : '0;
      exp_cr  = (load && ch == 1) ? onehot : '0;
      if (model_live) begin
         chk("a_ready", a_ready, exp_ar);
         chk("c_ready", c_ready, exp_cr);
         chk("arb_busy", arb_busy, m_valid || a_any || c_any);
         chk("arb_valid", arb_valid, m_valid);
         if (m_valid) begin
            logic [N-1:0] moh;
            moh = '0;
            moh[m_id] = 1'b1;
            chk("arb_channel", arb_channel, m_ch);
            chk("arb_master_id", arb_id, m_id);
            chk("arb_master_oh", arb_oh, moh);
            chk("arb_opcode", arb_opcode, m_op);
         end
      end
      if (rst) begin
         m_ptr[0] = 0; m_ptr[1] = 0; m_cnt = 0;
         m_valid = 0; m_ch = 0; m_id = 0; m_op = 0;
         model_live = 1'b1;
      end else begin
         if (!a_any || (load && ch == 0)) m_cnt = 0;
         else if (load && ch == 1 && m_cnt < LIM) m_cnt = m_cnt + 1;
         if (load) begin
            m_valid   = 1;
            m_ch      = ch;
            m_id      = idx;
            m_op      = ch ? int'(c_op[idx*OW +: OW]) : int'(a_op[idx*OW +: OW]);
            m_ptr[ch] = (idx + 1) % N;
         end else if (arb_ready) begin
            m_valid = 0;
         end
      end
   end

   task automatic drive(input logic r, input logic [N-1:0] av, input logic [N-1:0] cv,
                        input logic rdy);
      @(posedge clk);
      #1;
      rst = r; a_valid = av; c_valid = cv; arb_ready = rdy;
      a_op = N*OW'($urandom);
      c_op = N*OW'($urandom);
   endtask

   initial begin
      int exp_ch[6], exp_id[6];

      drive(1'b1, 5'b00000, 5'b00000, 1'b1);
      drive(1'b1, 5'b10101, 5'b01010, 1'b1);
      @(negedge clk);
      chk("reset_arb_valid", arb_valid, 1'b0);
      chk("reset_a_ready", a_ready, 5'b00000);
      chk("reset_c_ready", c_ready, 5'b00000);

      // A masters 1 and 3: round-robin 1, 3, 1.
      drive(1'b0, 5'b01010, 5'b00000, 1'b1);
      @(negedge clk);
      chk("t1_first_ready", a_ready, 5'b00010);
      @(negedge clk);
      chk("t1_valid", arb_valid, 1'b1);
      chk("t1_id0", arb_id, 1);
      chk("t1_chan", arb_channel, 1'b0);
      @(negedge clk);
      chk("t1_id1", arb_id, 3);
      @(negedge clk);
      chk("t1_id2", arb_id, 1);

      // C master 2 against A master 0.
      drive(1'b0, 5'b00001, 5'b00100, 1'b1);
      @(posedge clk);
      for (int k = 0; k < 6; k++) begin
         exp_ch[k] = (GUARD && (k % 3 == 2)) ? 0 : 1;
         exp_id[k] = exp_ch[k] ? 2 : 0;
         @(negedge clk);
         chk("t2_chan", arb_channel, exp_ch[k]);
         chk("t2_id", arb_id, exp_id[k]);
      end

      // Stall with other masters pending, then release.
      drive(1'b0, 5'b11111, 5'b00000, 1'b1);
      drive(1'b0, 5'b11111, 5'b00000, 1'b0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("t3_stall_aready", a_ready, 5'b00000);
         chk("t3_stall_valid", arb_valid, 1'b1);
         if (k < 4) begin @(posedge clk); #1; end
      end
      drive(1'b0, 5'b11111, 5'b00000, 1'b1);
      @(negedge clk);
      chk("t3_release_onehot", $countones(a_ready), 1);

      // Reset with a full stalled slot, then wrap order on five masters.
      drive(1'b0, 5'b11111, 5'b00100, 1'b0);
      drive(1'b1, 5'b11111, 5'b00100, 1'b0);
      @(negedge clk);
      chk("t6_rst_aready", a_ready, 5'b00000);
      chk("t6_rst_cready", c_ready, 5'b00000);
      drive(1'b0, 5'b11111, 5'b00000, 1'b1);
      @(negedge clk);
      chk("t6_after_rst_valid", arb_valid, 1'b0);
      chk("t6_ptr_zero", a_ready, 5'b00001);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("t4_wrap_id", arb_id, k % N);
      end

      for (int k = 0; k < 3000; k++) begin
         logic [N-1:0] av, cv;
         av = N'($urandom) & N'($urandom);
         cv = N'($urandom) & N'($urandom) & N'($urandom);
         drive(($urandom_range(0, 99) == 0), av, cv, ($urandom_range(0, 3) != 0));
      end
      drive(1'b0, 5'b00000, 5'b00000, 1'b1);
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
